// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the sequencer state set, error cause codes and the default reset PC.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        ERROR
    } fetchState_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } errCause_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/ready handshake between the fetch sequencer and imem.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_sequencer_timeout_ctr.sv
// Counts FETCH cycles spent waiting for imem; flags expiry once MAX_WAIT cycles have passed.
module fetch_timeout_ctr #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] waitCnt;

    // Saturates at MAX_WAIT so a stalled sequencer can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (clr) begin
            waitCnt <= '0;
        end else if (inc && !expired) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign expired = (waitCnt == CW'(MAX_WAIT));
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and steps the multicycle core through fetch and execute,
// with imem timeout, halt handling, target alignment checking and a retired count.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = 1,
    parameter int                MAX_WAIT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               halt,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               instr_done,
    input  logic [ADDR_W-1:0]  next_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_seq,
    output logic [31:0]        instr_count,
    output logic               fetch_err,
    output logic [1:0]         err_cause
);
    fetchState_t state, stateNext;
    errCause_t   errCauseQ, causeNext;
    logic        haltPend, haltPendNext;
    logic        loadInstr, retire, misalign, expired, reqQ;

    assign misalign = (PC_STEP == 4) && (next_addr[1:0] != 2'b00);

    fetch_timeout_ctr #(.MAX_WAIT(MAX_WAIT)) timeoutCtr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state != FETCH) || imem.ready),
        .inc     ((state == FETCH) && !imem.ready),
        .expired (expired)
    );

    // Next state plus the one-shot load/retire strobes for the datapath registers.
    always_comb begin
        stateNext    = state;
        causeNext    = errCauseQ;
        haltPendNext = haltPend;
        loadInstr    = 1'b0;
        retire       = 1'b0;
        case (state)
            IDLE: begin
                if (halt)        stateNext = HALTED;
                else if (enable) stateNext = FETCH;
            end
            FETCH: begin
                haltPendNext = haltPend | halt;
                if (imem.ready) begin
                    // A pending halt throws the returned word away instead of executing it.
                    if (haltPend || halt) begin
                        stateNext = HALTED;
                    end else begin
                        stateNext = EXEC;
                        loadInstr = 1'b1;
                    end
                end else if (expired) begin
                    stateNext = ERROR;
                    causeNext = ERR_TIMEOUT;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    if (misalign) begin
                        stateNext = ERROR;
                        causeNext = ERR_MISALIGN;
                    end else begin
                        retire = 1'b1;
                        if (halt)        stateNext = HALTED;
                        else if (enable) stateNext = FETCH;
                        else             stateNext = IDLE;
                    end
                end
            end
            default: stateNext = state;
        endcase
    end

    // Status outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_count <= '0;
            errCauseQ   <= ERR_NONE;
            haltPend    <= 1'b0;
            reqQ        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= stateNext;
            errCauseQ   <= causeNext;
            haltPend    <= haltPendNext;
            reqQ        <= (stateNext == FETCH);
            instr_valid <= (stateNext == EXEC);
            fetch_err   <= (stateNext == ERROR);
            if (loadInstr) instr <= imem.rdata;
            if (retire) begin
                pc          <= next_addr;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign imem.req  = reqQ;
    assign imem.addr = pc;
    assign pc_seq    = pc + ADDR_W'(PC_STEP);
    assign err_cause = errCauseQ;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a transaction-level expectation model checked every
// cycle on a word-addressed instance, plus directed literal checks on a byte-addressed instance.
module tb_fetch_sequencer;
    localparam int          AW  = 32;
    localparam logic [31:0] RPC = 32'h40;
    localparam int          MW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Word-addressed instance under the per-cycle model.
    logic        enable, halt, instr_done;
    logic [31:0] next_addr, instr, instr_count, pc, pc_seq;
    logic        instr_valid, fetch_err;
    logic [1:0]  err_cause;
    fetch_sequencer_if #(.ADDR_W(AW)) imemA ();

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(RPC), .PC_STEP(1), .MAX_WAIT(MW)) dutA (
        .clk(clk), .rst_n(rst_n), .enable(enable), .halt(halt), .imem(imemA),
        .instr(instr), .instr_valid(instr_valid), .instr_done(instr_done),
        .next_addr(next_addr), .pc(pc), .pc_seq(pc_seq), .instr_count(instr_count),
        .fetch_err(fetch_err), .err_cause(err_cause)
    );

    // Byte-addressed instance for the alignment check.
    logic        enableB, haltB, doneB;
    logic [31:0] nextB, instrB, countB, pcB, pcSeqB;
    logic        validB, errB;
    logic [1:0]  causeB;
    fetch_sequencer_if #(.ADDR_W(AW)) imemB ();

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(32'h100), .PC_STEP(4), .MAX_WAIT(MW)) dutB (
        .clk(clk), .rst_n(rst_n), .enable(enableB), .halt(haltB), .imem(imemB),
        .instr(instrB), .instr_valid(validB), .instr_done(doneB),
        .next_addr(nextB), .pc(pcB), .pc_seq(pcSeqB), .instr_count(countB),
        .fetch_err(errB), .err_cause(causeB)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] expPc, expInstr, expCount, seqExp;
    logic        expReq, expValid, expErr;
    logic [1:0]  expCause;
    bit          modelOn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelOn) begin
            seqExp = expPc + 32'd1;
            checkOutput("pc", pc, expPc);
            checkOutput("pc_seq", pc_seq, seqExp);
            checkOutput("imem_addr", imemA.addr, expPc);
            checkOutput("imem_req", imemA.req, expReq);
            checkOutput("instr_valid", instr_valid, expValid);
            checkOutput("instr", instr, expInstr);
            checkOutput("instr_count", instr_count, expCount);
            checkOutput("fetch_err", fetch_err, expErr);
            checkOutput("err_cause", err_cause, expCause);
        end
    end

    task automatic resetExpect();
        expPc = RPC; expInstr = '0; expCount = '0;
        expReq = 1'b0; expValid = 1'b0; expErr = 1'b0; expCause = 2'b00;
    endtask

    task automatic applyStimulus(input logic en, input logic hl, input logic rdy,
                                 input logic [31:0] word, input logic dn, input logic [31:0] na);
        enable = en; halt = hl; imemA.ready = rdy; imemA.rdata = word;
        instr_done = dn; next_addr = na;
        @(posedge clk); #1;
        imemA.ready = 1'b0; instr_done = 1'b0; halt = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        enable = 1'b0; halt = 1'b0; instr_done = 1'b0; next_addr = '0;
        imemA.ready = 1'b0; imemA.rdata = '0;
        enableB = 1'b0; haltB = 1'b0; doneB = 1'b0; nextB = '0;
        imemB.ready = 1'b0; imemB.rdata = '0;
        resetExpect();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic startFetch();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expReq = 1'b1;
    endtask

    task automatic fetchWord(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, word, 1'b0, 32'h0);
        expReq = 1'b0; expValid = 1'b1; expInstr = word;
    endtask

    // One held EXEC cycle (with a stray ready that must be ignored), then retirement.
    task automatic retire(input logic [31:0] addr, input logic en, input logic hl);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 32'h0);
        applyStimulus(en, hl, 1'b0, 32'h0, 1'b1, addr);
        expValid = 1'b0; expPc = addr; expCount = expCount + 32'd1;
        expReq = en && !hl;
    endtask

    initial begin
        rst_n = 1'b0;
        resetExpect();
        modelOn = 1'b1;
        doReset();
        checkOutput("reset_pc", pc, 32'h40);
        checkOutput("reset_count", instr_count, 32'h0);
        checkOutput("reset_req", imemA.req, 1'b0);

        // Straight-line fetch, execute and retire.
        startFetch();
        checkOutput("t1_addr", imemA.addr, 32'h40);
        fetchWord(0, 32'h2002000A);
        checkOutput("t1_instr", instr, 32'h2002000A);
        retire(32'h41, 1'b0, 1'b0);
        checkOutput("t1_pc", pc, 32'h41);
        checkOutput("t1_count", instr_count, 32'd1);
        checkOutput("t1_pc_seq", pc_seq, 32'h42);

        // Taken branch: the next fetch goes straight to the target.
        startFetch();
        fetchWord(2, 32'h11111111);
        retire(32'h10, 1'b1, 1'b0);
        checkOutput("t2_addr", imemA.addr, 32'h10);
        checkOutput("t2_req", imemA.req, 1'b1);

        // Ready on the very cycle the timeout would fire still completes the fetch.
        fetchWord(MW, 32'h22222222);
        checkOutput("ready_wins_valid", instr_valid, 1'b1);
        retire(32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("wrap_pc_seq", pc_seq, 32'h0);
        checkOutput("wrap_no_err", fetch_err, 1'b0);

        startFetch();
        fetchWord(1, 32'h33333333);
        retire(32'h7, 1'b1, 1'b0);
        checkOutput("t6_pc_before", pc, 32'h7);

        // Asynchronous reset in the middle of a fetch, with a late ready.
        @(posedge clk); #3;
        rst_n = 1'b0; imemA.ready = 1'b1; enable = 1'b0;
        #1;
        resetExpect();
        checkOutput("t6_async_pc", pc, 32'h40);
        checkOutput("t6_async_req", imemA.req, 1'b0);
        checkOutput("t6_async_count", instr_count, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; imemA.ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Halt raised mid-fetch discards the returned word.
        startFetch();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        expReq = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 32'h99);
        checkOutput("t5_valid", instr_valid, 1'b0);
        checkOutput("t5_count", instr_count, 32'h0);

        // Fetch timeout, then a late ready that must change nothing.
        doReset();
        startFetch();
        for (int i = 0; i < MW; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expReq = 1'b0; expErr = 1'b1; expCause = 2'b01;
        checkOutput("t3_err", fetch_err, 1'b1);
        checkOutput("t3_cause", err_cause, 2'b01);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h99);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Halt in IDLE, and halt together with instr_done.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        doReset();
        startFetch();
        fetchWord(0, 32'h44444444);
        retire(32'h50, 1'b1, 1'b1);
        checkOutput("exec_halt_pc", pc, 32'h50);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 32'h0);

        // Byte-addressed instance: aligned retire, then a misaligned target.
        doReset();
        checkOutput("b_reset_pc", pcB, 32'h100);
        checkOutput("b_pc_seq", pcSeqB, 32'h104);
        enableB = 1'b1;
        @(posedge clk); #1;
        checkOutput("b_req", imemB.req, 1'b1);
        checkOutput("b_addr", imemB.addr, 32'h100);
        imemB.ready = 1'b1; imemB.rdata = 32'hCAFE0001;
        @(posedge clk); #1;
        imemB.ready = 1'b0;
        checkOutput("b_valid", validB, 1'b1);
        checkOutput("b_instr", instrB, 32'hCAFE0001);
        doneB = 1'b1; nextB = 32'h108;
        @(posedge clk); #1;
        doneB = 1'b0;
        checkOutput("b_pc", pcB, 32'h108);
        checkOutput("b_count", countB, 32'd1);
        checkOutput("b_pc_seq2", pcSeqB, 32'h10C);
        imemB.ready = 1'b1;
        @(posedge clk); #1;
        imemB.ready = 1'b0;
        doneB = 1'b1; nextB = 32'h102;
        @(posedge clk); #1;
        doneB = 1'b0;
        checkOutput("t4_err", errB, 1'b1);
        checkOutput("t4_cause", causeB, 2'b10);
        checkOutput("t4_pc", pcB, 32'h108);
        checkOutput("t4_count", countB, 32'd1);
        checkOutput("t4_valid", validB, 1'b0);
        checkOutput("t4_req", imemB.req, 1'b0);
        imemB.ready = 1'b1;
        @(posedge clk); #1;
        imemB.ready = 1'b0;
        checkOutput("t4_sticky", errB, 1'b1);

        @(negedge clk);
        modelOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
